dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory of `simple_cpu` between the CPU load/store unit and a debug/loader port. The debug/loader port preloads or inspects memory while the core runs. Each cycle it grants at most one requester, drives the memory port from the winner, and routes read data back to the owner one cycle later. A starvation counter guarantees the debug port progress under continuous CPU traffic.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arb_pick.sv | 46 ++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin arbitration.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 7;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CONFLICT_W     = 16;

    localparam logic [CONFLICT_W-1:0] CONFLICT_MAX = 16'hFFFF;

    // Owner of an access or of a pending read response
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, debug/loader port and memory port of the arbiter.
// Optional feature macro: DMEM_ARB_RR_EN (no effect on the bundle itself).
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    // CPU load/store unit port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Debug/loader port
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    // Single-port memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic [CONFLICT_W-1:0] conflict_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the CPU and debug requesters.
// Optional feature macro: DMEM_ARB_RR_EN replaces the starvation override
// with round-robin on conflict.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned STARVE_W   = $clog2(STARVE_MAX + 1)
) (
    input  logic                i_cpu_req,
    input  logic                i_dbg_req,
`ifdef DMEM_ARB_RR_EN
    input  owner_t              i_last_owner,
`else
    input  logic [STARVE_W-1:0] i_starve_cnt,
`endif
    output logic                o_cpu_win,
    output logic                o_dbg_win
);

    // Lone requester always wins; on conflict apply the configured policy
    always_comb begin
        o_cpu_win = 1'b0;
        o_dbg_win = 1'b0;
        if (i_cpu_req && i_dbg_req) begin
`ifdef DMEM_ARB_RR_EN
            if (i_last_owner == OWN_DBG) begin
                o_cpu_win = 1'b1;
            end else begin
                o_dbg_win = 1'b1;
            end
`else
            if (i_starve_cnt == STARVE_W'(STARVE_MAX)) begin
                o_dbg_win = 1'b1;
            end else begin
                o_cpu_win = 1'b1;
            end
`endif
        end else if (i_cpu_req) begin
            o_cpu_win = 1'b1;
        end else if (i_dbg_req) begin
            o_dbg_win = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and a debug/loader port.
// Grants are combinational, read data returns to its owner one cycle later.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin on conflict
// instead of fixed CPU priority with a starvation override.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic                  w_cpu_win;
    logic                  w_dbg_win;
    logic                  w_conflict;
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;
    logic [DATA_W-1:0]     w_cpu_rdata;
    logic [DATA_W-1:0]     w_dbg_rdata;

    owner_t                r_rsp_owner;
    owner_t                w_rsp_owner_nxt;
    logic [CONFLICT_W-1:0] r_conflict_cnt;
    logic [CONFLICT_W-1:0] w_conflict_cnt_nxt;

`ifdef DMEM_ARB_RR_EN
    owner_t                r_last_owner;
    owner_t                w_last_owner_nxt;
`else
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic [STARVE_W-1:0]   w_starve_cnt_nxt;
`endif

    assign w_conflict = bus.cpu_req & bus.dbg_req;

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_pick (
        .i_cpu_req    (bus.cpu_req),
        .i_dbg_req    (bus.dbg_req),
`ifdef DMEM_ARB_RR_EN
        .i_last_owner (r_last_owner),
`else
        .i_starve_cnt (r_starve_cnt),
`endif
        .o_cpu_win    (w_cpu_win),
        .o_dbg_win    (w_dbg_win)
    );

    // Memory port is driven by the winner, all-zero when idle
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_cpu_win) begin
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end else if (w_dbg_win) begin
            w_mem_we    = bus.dbg_we;
            w_mem_addr  = bus.dbg_addr;
            w_mem_wdata = bus.dbg_wdata;
        end
    end

    // Read data is steered to the owner of last cycle's read, zero otherwise
    always_comb begin
        w_cpu_rdata = '0;
        w_dbg_rdata = '0;
        if (r_rsp_owner == OWN_CPU) begin
            w_cpu_rdata = bus.mem_rdata;
        end
        if (r_rsp_owner == OWN_DBG) begin
            w_dbg_rdata = bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt      = w_cpu_win;
    assign bus.dbg_gnt      = w_dbg_win;
    assign bus.mem_en       = w_cpu_win | w_dbg_win;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.cpu_rvalid   = (r_rsp_owner == OWN_CPU);
    assign bus.dbg_rvalid   = (r_rsp_owner == OWN_DBG);
    assign bus.cpu_rdata    = w_cpu_rdata;
    assign bus.dbg_rdata    = w_dbg_rdata;
    assign bus.conflict_cnt = r_conflict_cnt;

    // Next-state: response owner, saturating conflict counter, policy state
    always_comb begin
        w_rsp_owner_nxt    = OWN_NONE;
        w_conflict_cnt_nxt = r_conflict_cnt;
`ifdef DMEM_ARB_RR_EN
        w_last_owner_nxt   = r_last_owner;
`else
        w_starve_cnt_nxt   = '0;
`endif

        if (w_cpu_win && !bus.cpu_we) begin
            w_rsp_owner_nxt = OWN_CPU;
        end else if (w_dbg_win && !bus.dbg_we) begin
            w_rsp_owner_nxt = OWN_DBG;
        end

        if (w_conflict && (r_conflict_cnt != CONFLICT_MAX)) begin
            w_conflict_cnt_nxt = r_conflict_cnt + CONFLICT_W'(1);
        end

`ifdef DMEM_ARB_RR_EN
        if (w_cpu_win) begin
            w_last_owner_nxt = OWN_CPU;
        end else if (w_dbg_win) begin
            w_last_owner_nxt = OWN_DBG;
        end
`else
        if (bus.dbg_req && !w_dbg_win) begin
            if (r_starve_cnt == STARVE_W'(STARVE_MAX)) begin
                w_starve_cnt_nxt = r_starve_cnt;
            end else begin
                w_starve_cnt_nxt = r_starve_cnt + STARVE_W'(1);
            end
        end
`endif
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_owner    <= OWN_NONE;
            r_conflict_cnt <= '0;
`ifdef DMEM_ARB_RR_EN
            r_last_owner   <= OWN_CPU;
`else
            r_starve_cnt   <= '0;
`endif
        end else begin
            r_rsp_owner    <= w_rsp_owner_nxt;
            r_conflict_cnt <= w_conflict_cnt_nxt;
`ifdef DMEM_ARB_RR_EN
            r_last_owner   <= w_last_owner_nxt;
`else
            r_starve_cnt   <= w_starve_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Optional feature macro: DMEM_ARB_RR_EN selects the round-robin sequence.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
`ifdef DMEM_ARB_RR_EN
    localparam int unsigned T2_CYCLES  = 6;
`else
    localparam int unsigned T2_CYCLES  = 5;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] mem [128];

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory, read data valid the cycle after access
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[1] = 32'h0000_1111;
        mem[2] = 32'h0000_2222;
        mem[3] = 32'h0000_3333;
        mem[5] = 32'h0000_0037;
        bus.mem_rdata = '0;

        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

        // Reset values
        #2;
        chk("rst_cpu_gnt",    32'(bus.cpu_gnt),      32'd0);
        chk("rst_dbg_gnt",    32'(bus.dbg_gnt),      32'd0);
        chk("rst_mem_en",     32'(bus.mem_en),       32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr),     32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,         32'd0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid),   32'd0);
        chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid),   32'd0);
        chk("rst_cpu_rdata",  bus.cpu_rdata,         32'd0);
        chk("rst_conflict",   32'(bus.conflict_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // CPU-only read of addr 5
        bus.cpu_req = 1; bus.cpu_addr = 7'd5;
        #1;
        chk("t1_cpu_gnt",  32'(bus.cpu_gnt),  32'd1);
        chk("t1_dbg_gnt",  32'(bus.dbg_gnt),  32'd0);
        chk("t1_mem_en",   32'(bus.mem_en),   32'd1);
        chk("t1_mem_we",   32'(bus.mem_we),   32'd0);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'd5);
        @(posedge clk); #1;
        bus.cpu_req = 0;
        chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t1_cpu_rdata",  bus.cpu_rdata,       32'h0000_0037);
        chk("t1_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("t1_dbg_rdata",  bus.dbg_rdata,       32'd0);
        @(posedge clk); #1;
        chk("t1_cpu_rvalid_off", 32'(bus.cpu_rvalid), 32'd0);

        // Both requesting continuously
        bus.cpu_req = 1; bus.cpu_addr = 7'd1;
        bus.dbg_req = 1; bus.dbg_addr = 7'd2;
        for (int k = 1; k <= int'(T2_CYCLES); k++) begin
            #1;
`ifdef DMEM_ARB_RR_EN
            chk("t2_rr_dbg_gnt", 32'(bus.dbg_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("t2_rr_cpu_gnt", 32'(bus.cpu_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
`else
            chk("t2_cpu_gnt", 32'(bus.cpu_gnt), (k < 5) ? 32'd1 : 32'd0);
            chk("t2_dbg_gnt", 32'(bus.dbg_gnt), (k == 5) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            chk("t2_starve", 32'(dut.r_starve_cnt), (k == 5) ? 32'd0 : 32'(k));
            if (k == 1) chk("t2_cpu_rdata", bus.cpu_rdata, 32'h0000_1111);
`endif
        end
`ifdef DMEM_ARB_RR_EN
        chk("t2_rr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t2_rr_cpu_rdata",  bus.cpu_rdata,       32'h0000_1111);
`else
        chk("t2_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("t2_dbg_rdata",  bus.dbg_rdata,       32'h0000_2222);
        chk("t2_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
`endif
        chk("t2_conflict", 32'(bus.conflict_cnt), 32'(T2_CYCLES));
        bus.cpu_req = 0; bus.dbg_req = 0;

        // Debug write to addr 127, then CPU read back
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 7'd127; bus.dbg_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t3_dbg_gnt",   32'(bus.dbg_gnt),  32'd1);
        chk("t3_mem_we",    32'(bus.mem_we),   32'd1);
        chk("t3_mem_addr",  32'(bus.mem_addr), 32'd127);
        chk("t3_mem_wdata", bus.mem_wdata,     32'hDEAD_BEEF);
        @(posedge clk); #1;
        bus.dbg_req = 0; bus.dbg_we = 0;
        chk("t3_cpu_rvalid_wr", 32'(bus.cpu_rvalid), 32'd0);
        chk("t3_dbg_rvalid_wr", 32'(bus.dbg_rvalid), 32'd0);
        bus.cpu_req = 1; bus.cpu_addr = 7'd127;
        #1;
        chk("t3_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        @(posedge clk); #1;
        bus.cpu_req = 0;
        chk("t3_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t3_cpu_rdata",  bus.cpu_rdata,       32'hDEAD_BEEF);

        // Alternating owners back to back: CPU@1, DBG@2, CPU@3
        bus.cpu_req = 1; bus.cpu_addr = 7'd1;
        @(posedge clk); #1;
        bus.cpu_req = 0;
        bus.dbg_req = 1; bus.dbg_addr = 7'd2;
        chk("t4_cpu_rvalid_a", 32'(bus.cpu_rvalid), 32'd1);
        chk("t4_cpu_rdata_a",  bus.cpu_rdata,       32'h0000_1111);
        @(posedge clk); #1;
        bus.dbg_req = 0;
        bus.cpu_req = 1; bus.cpu_addr = 7'd3;
        chk("t4_dbg_rvalid_b", 32'(bus.dbg_rvalid), 32'd1);
        chk("t4_dbg_rdata_b",  bus.dbg_rdata,       32'h0000_2222);
        chk("t4_cpu_rvalid_b", 32'(bus.cpu_rvalid), 32'd0);
        @(posedge clk); #1;
        bus.cpu_req = 0;
        chk("t4_cpu_rvalid_c", 32'(bus.cpu_rvalid), 32'd1);
        chk("t4_cpu_rdata_c",  bus.cpu_rdata,       32'h0000_3333);
        chk("t4_dbg_rvalid_c", 32'(bus.dbg_rvalid), 32'd0);

        // Asynchronous reset mid-cycle while a CPU read is granted
        bus.cpu_req = 1; bus.cpu_addr = 7'd5;
        bus.dbg_req = 1; bus.dbg_addr = 7'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_conflict_pre", 32'(bus.conflict_cnt), 32'(T2_CYCLES + 2));
`ifndef DMEM_ARB_RR_EN
        chk("t5_starve_pre", 32'(dut.r_starve_cnt), 32'd2);
`endif
        bus.dbg_req = 0;
        #1;
        chk("t5_cpu_gnt",        32'(bus.cpu_gnt),    32'd1);
        chk("t5_cpu_rvalid_pre", 32'(bus.cpu_rvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_conflict_rst",   32'(bus.conflict_cnt), 32'd0);
`ifndef DMEM_ARB_RR_EN
        chk("t5_starve_rst",     32'(dut.r_starve_cnt), 32'd0);
`endif
        chk("t5_cpu_rvalid_rst", 32'(bus.cpu_rvalid), 32'd0);
        chk("t5_cpu_rdata_rst",  bus.cpu_rdata,       32'd0);
        chk("t5_cpu_gnt_rst",    32'(bus.cpu_gnt),    32'd1);
        bus.cpu_req = 0;
        @(posedge clk); #1;
        chk("t5_cpu_rvalid_edge", 32'(bus.cpu_rvalid), 32'd0);
        chk("t5_mem_en_idle",     32'(bus.mem_en),     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_cpu_rvalid_post", 32'(bus.cpu_rvalid), 32'd0);
        chk("t5_conflict_post",   32'(bus.conflict_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
